// File: rtl/prefix_add_pkg.sv
// ----------------------------------------------------------------------------
// prefix_add_pkg
// Shared definitions for the packet accumulator and its prefix adder:
//   - default operand limit and counter width of accum8_seq
//   - FSM state encoding (ACCUM = 0, DONE = 1)
// ----------------------------------------------------------------------------
package prefix_add_pkg;

    // Default maximum operands per packet (legal range 2..15).
    localparam int MAX_OPS_DEF = 15;

    // Default width of the operand and wrap counters; must hold MAX_OPS.
    localparam int CNT_W_DEF = 4;

    // Width of operands, adder and accumulator.
    localparam int DATA_W = 8;

    // Accumulator FSM: collecting operands, or holding a finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

endpackage : prefix_add_pkg

// File: rtl/prefix_add8.sv
// ----------------------------------------------------------------------------
// prefix_add8
// Purely combinational 8-bit adder built as a Kogge-Stone parallel-prefix
// network. The sum is returned modulo 256; the caller detects carry-out by
// comparing the sum against an operand.
//
// Ports
//   a   : input  [7:0]  first operand
//   b   : input  [7:0]  second operand
//   sum : output [7:0]  (a + b) mod 256
// ----------------------------------------------------------------------------
module prefix_add8
    import prefix_add_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    // Number of prefix levels for an 8-bit span: log2(8).
    localparam int LEVELS = 3;

    // gen[k][i]  : group generate over bits (i - 2^k + 1) .. i
    // prop[k][i] : group propagate over the same span (only needed up to
    //              the level before last, the final level consumes it).
    logic [LEVELS:0][DATA_W-1:0]   gen;
    logic [LEVELS-1:0][DATA_W-1:0] prop;
    logic [DATA_W-1:0]             carry;

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path before it is read, so no storage (latch) is ever implied.
    always_comb begin
        gen  = '0;
        prop = '0;

        // Level 0: bitwise generate / propagate.
        gen[0]  = a & b;
        prop[0] = a ^ b;

        // Levels 1..LEVELS: combine each bit with the span 2^(k-1) below it.
        // Bits closer to the LSB than that distance already hold their
        // final prefix and are passed through unchanged.
        for (int k = 1; k <= LEVELS; k++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (i >= (1 << (k - 1))) begin
                    gen[k][i] = gen[k-1][i]
                              | (prop[k-1][i] & gen[k-1][i - (1 << (k - 1))]);
                    if (k < LEVELS) begin
                        prop[k][i] = prop[k-1][i] & prop[k-1][i - (1 << (k - 1))];
                    end
                end else begin
                    gen[k][i] = gen[k-1][i];
                    if (k < LEVELS) begin
                        prop[k][i] = prop[k-1][i];
                    end
                end
            end
        end

        // Carry into bit i is the full prefix generate of bits 0..i-1.
        // The carry out of bit 7 is not needed: the sum wraps modulo 256.
        carry[0] = 1'b0;
        for (int i = 1; i < DATA_W; i++) begin
            carry[i] = gen[LEVELS][i-1];
        end
    end

    assign sum = prop[0] ^ carry;

endmodule : prefix_add8

// File: rtl/accum8_seq.sv
// ----------------------------------------------------------------------------
// accum8_seq
// Packet accumulator. Operands arrive on a valid/ready stream and are summed
// modulo 256 until in_last is seen or MAX_OPS operands have been taken. The
// result (sum, operand count, number of 8-bit wrap-arounds, truncation flag)
// is then held on a valid/ready output until consumed, after which the block
// clears and accepts the next packet.
//
// Parameters
//   MAX_OPS : maximum operands per packet (2..15)
//   CNT_W   : width of the operand and wrap counters (MAX_OPS must fit)
//
// Ports
//   clk       : input          clock, rising edge
//   rst       : input          synchronous active-high reset
//   in_valid  : input          operand available
//   in_ready  : output         operand accepted this cycle when valid
//   in_data   : input  [7:0]   unsigned operand
//   in_last   : input          final operand of the packet
//   out_valid : output         result held on out_*
//   out_ready : input          consumer takes the result
//   out_sum   : output [7:0]   packet sum modulo 256
//   out_count : output [CNT_W] operands accepted in the packet
//   out_wrap  : output [CNT_W] wrap-arounds seen, saturating
//   out_trunc : output         packet closed by MAX_OPS rather than in_last
// ----------------------------------------------------------------------------
module accum8_seq
    import prefix_add_pkg::*;
#(
    parameter int MAX_OPS = MAX_OPS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic [CNT_W-1:0]  out_wrap,
    output logic              out_trunc
);

    // Saturation ceiling of the wrap counter.
    localparam logic [CNT_W-1:0] WRAP_MAX = '1;
    // Operand limit expressed in counter width.
    localparam logic [CNT_W-1:0] OPS_LIM  = CNT_W'(MAX_OPS);

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   acc_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [CNT_W-1:0]    wrap;
    logic [CNT_W-1:0]    wrap_nx;
    logic                trunc;
    logic                trunc_nx;

    logic [DATA_W-1:0]   add_sum;
    logic [CNT_W-1:0]    cnt_inc;
    logic                wrapped;

    // The only adder in the design: acc + in_data.
    prefix_add8 u_add (
        .a   (acc),
        .b   (in_data),
        .sum (add_sum)
    );

    // A modulo-256 sum smaller than the running total means a carry out.
    assign wrapped = (add_sum < acc);
    assign cnt_inc = cnt + CNT_W'(1);

    // Handshake flags decode directly from the state.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);

    // Result ports come straight from the registers so they are glitch-free
    // and stable for the whole DONE period.
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_wrap  = wrap;
    assign out_trunc = trunc;

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        wrap_nx  = wrap;
        trunc_nx = trunc;

        case (state)
            ACCUM: begin
                // in_ready is 1 here, so in_valid alone means acceptance.
                // out_ready has no effect in this state.
                if (in_valid) begin
                    acc_nx = add_sum;
                    cnt_nx = cnt_inc;
                    if (wrapped && (wrap != WRAP_MAX)) begin
                        wrap_nx = wrap + CNT_W'(1);
                    end
                    // in_last wins over the limit, so a packet that ends
                    // exactly at MAX_OPS is not flagged as truncated.
                    if (in_last) begin
                        state_nx = DONE;
                        trunc_nx = 1'b0;
                    end else if (cnt_inc == OPS_LIM) begin
                        state_nx = DONE;
                        trunc_nx = 1'b1;
                    end
                end
            end

            DONE: begin
                // Input side is stalled; only the output handshake matters.
                if (out_ready) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    wrap_nx  = '0;
                    trunc_nx = 1'b0;
                end
            end

            default: begin
                state_nx = ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Reset overrides any handshake in the
    // same cycle and throws away a partial or pending result.
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            wrap  <= '0;
            trunc <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            wrap  <= wrap_nx;
            trunc <= trunc_nx;
        end
    end

endmodule : accum8_seq

// File: tb/tb_accum8_seq.sv
// ----------------------------------------------------------------------------
// tb_accum8_seq
// Directed self-checking bench for accum8_seq (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_accum8_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_count;
    logic [3:0] out_wrap;
    logic       out_trunc;

    int n_cmp;
    int n_bad;

    accum8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_wrap  (out_wrap),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and advance past the edge that accepts it.
    task automatic send(input logic [7:0] d, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        tick();
    endtask

    // Result check bundle.
    task automatic check_result(input string tag, input logic [7:0] s, input logic [3:0] c,
                                input logic [3:0] w, input logic t);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   32'(s));
        check({tag, "_count"}, 32'(out_count), 32'(c));
        check({tag, "_wrap"},  32'(out_wrap),  32'(w));
        check({tag, "_trunc"}, 32'(out_trunc), 32'(t));
    endtask

    // Take the pending result with a one-cycle output handshake.
    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(out_sum),   32'd0);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_wrap",      32'(out_wrap),  32'd0);
        check("rst_trunc",     32'(out_trunc), 32'd0);

        // Packet 100, 24(last): result one cycle after the 24 is accepted.
        send(8'd100, 1'b0);
        check("p1_mid_valid", 32'(out_valid), 32'd0);
        send(8'd24, 1'b1);
        in_valid = 1'b0;
        check_result("p1", 8'd124, 4'd2, 4'd0, 1'b0);
        check("p1_in_ready", 32'(in_ready), 32'd0);
        consume();
        check("p1_post_valid", 32'(out_valid), 32'd0);
        check("p1_post_ready", 32'(in_ready),  32'd1);
        check("p1_post_sum",   32'(out_sum),   32'd0);

        // Packet 20, 178, 100(last): 298 -> 42 with one wrap.
        send(8'd20, 1'b0);
        send(8'd178, 1'b0);
        send(8'd100, 1'b1);
        in_valid = 1'b0;
        check_result("p2", 8'd42, 4'd3, 4'd1, 1'b0);
        consume();

        // Packet 177, 54, 90, 60(last): 381 -> 125, one wrap; stall output.
        send(8'd177, 1'b0);
        send(8'd54, 1'b0);
        send(8'd90, 1'b0);
        send(8'd60, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'd255;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("p3_hold_sum",   32'(out_sum),   32'd125);
            check("p3_hold_count", 32'(out_count), 32'd4);
            check("p3_hold_ready", 32'(in_ready),  32'd0);
            tick();
        end
        in_valid = 1'b0;
        check_result("p3", 8'd125, 4'd4, 4'd1, 1'b0);
        consume();

        // Fifteen 1s without in_last: closed by the limit.
        for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
        check_result("p4", 8'd15, 4'd15, 4'd0, 1'b1);
        // A 16th operand waits while the result is pending.
        in_valid = 1'b1;
        in_data  = 8'd7;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("p4_stall_ready", 32'(in_ready), 32'd0);
            check("p4_stall_sum",   32'(out_sum),  32'd15);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("p4_handoff_ready", 32'(in_ready),  32'd1);
        check("p4_handoff_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check_result("p5", 8'd7, 4'd1, 4'd0, 1'b0);
        consume();

        // in_last on the MAX_OPS-th operand: not truncated.
        for (int i = 0; i < 14; i++) send(8'd1, 1'b0);
        send(8'd2, 1'b1);
        in_valid = 1'b0;
        check_result("p6", 8'd16, 4'd15, 4'd0, 1'b0);
        consume();

        // Reset mid-packet discards 33 + 63.
        send(8'd33, 1'b0);
        send(8'd63, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("p7_rst_valid", 32'(out_valid), 32'd0);
        check("p7_rst_sum",   32'(out_sum),   32'd0);
        check("p7_rst_count", 32'(out_count), 32'd0);
        check("p7_rst_ready", 32'(in_ready),  32'd1);
        send(8'd24, 1'b0);
        send(8'd76, 1'b1);
        in_valid = 1'b0;
        check_result("p8", 8'd100, 4'd2, 4'd0, 1'b0);
        // Reset alongside an output handshake in DONE.
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        check("p8_rst_valid", 32'(out_valid), 32'd0);
        check("p8_rst_sum",   32'(out_sum),   32'd0);

        // Back-to-back packets with out_ready held high.
        out_ready = 1'b1;
        send(8'd200, 1'b0);
        send(8'd100, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'd5;
        in_last  = 1'b1;
        check_result("p9", 8'd44, 4'd2, 4'd1, 1'b0);
        check("p9_ready", 32'(in_ready), 32'd0);
        tick();
        check("bubble_valid", 32'(out_valid), 32'd0);
        check("bubble_ready", 32'(in_ready),  32'd1);
        check("bubble_sum",   32'(out_sum),   32'd0);
        tick();
        in_valid = 1'b0;
        check_result("p10", 8'd5, 4'd1, 4'd0, 1'b0);
        tick();
        check("p10_taken", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_accum8_seq
